// File: rtl/dmux_n_reg.sv
`default_nettype none
// ============================================================================
// Module      : dmux_n_reg
// Description : Registered 1-to-NCH demux, one holding register per channel
//               with valid/ready handshake. Optional DMUX_N_SELERR_EN build
//               adds a sticky bad-select flag and a saturating drop counter.
// Revision    : 1.0
// ============================================================================
module dmux_n_reg #(
    parameter int W    = 16,
    parameter int NCH  = 4,
    parameter int SELW = ($clog2(NCH) > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [W-1:0]         i,
    input  logic [SELW-1:0]      sel,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic                 flush,
    output logic [NCH*W-1:0]     o,
    output logic [NCH-1:0]       o_valid,
    input  logic [NCH-1:0]       o_ready
`ifdef DMUX_N_SELERR_EN
    ,
    output logic                 sel_err,
    output logic [7:0]           drop_cnt
`endif
);

    localparam logic [SELW:0] c_nch = (SELW+1)'(NCH);

    logic [NCH-1:0][W-1:0] r_d;
    logic [NCH-1:0]        r_v;
    logic [NCH-1:0]        w_free;
    logic [NCH-1:0]        w_load;
    logic                  w_in_range;
    logic                  w_xfer;
    logic                  w_ready;

    assign w_in_range = ({1'b0, sel} < c_nch);
    assign w_free     = ~r_v | o_ready;

    // Out-of-range selects are always accepted so a bad SEL cannot stall the source.
    always_comb begin
        w_ready = 1'b0;
        if (!flush) begin
            if (!w_in_range) begin
                w_ready = 1'b1;
            end else begin
                w_ready = w_free[sel];
            end
        end
    end

    assign i_ready = w_ready;
    assign w_xfer  = i_valid & w_ready;

    generate
        for (genvar k = 0; k < NCH; k++) begin : g_ch
            assign w_load[k] = w_xfer & w_in_range & (sel == SELW'(k));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_d[k] <= '0;
                    r_v[k] <= 1'b0;
                end else if (flush) begin
                    r_v[k] <= 1'b0;
                end else if (w_load[k]) begin
                    r_d[k] <= i;
                    r_v[k] <= 1'b1;
                end else if (o_ready[k]) begin
                    r_v[k] <= 1'b0;
                end
            end
        end
    endgenerate

    assign o       = r_d;
    assign o_valid = r_v;

`ifdef DMUX_N_SELERR_EN
    logic       r_sel_err;
    logic [7:0] r_drop_cnt;
    logic       w_drop;

    assign w_drop = w_xfer & ~w_in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_err  <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else if (w_drop) begin
            r_sel_err <= 1'b1;
            if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign sel_err  = r_sel_err;
    assign drop_cnt = r_drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmux_n_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmux_n_reg
// Description : Scoreboard bench for dmux_n_reg (NCH=4 main instance plus an
//               NCH=3 instance for out-of-range selects).
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_dmux_n_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din;
    logic [1:0]  sel;
    logic        i_valid, i_ready, flush;
    logic [63:0] o;
    logic [3:0]  o_valid, o_ready;

    logic [15:0] d3;
    logic [1:0]  sel3;
    logic        i3_valid, i3_ready, flush3;
    logic [47:0] o3;
    logic [2:0]  o3_valid, o3_ready;

`ifdef DMUX_N_SELERR_EN
    logic       sel_err, sel_err3;
    logic [7:0] drop_cnt, drop_cnt3;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp_q [4][$];

    always #5 clk = ~clk;

    dmux_n_reg #(.W(16), .NCH(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .i(din), .sel(sel), .i_valid(i_valid),
        .i_ready(i_ready), .flush(flush), .o(o), .o_valid(o_valid),
        .o_ready(o_ready)
`ifdef DMUX_N_SELERR_EN
        , .sel_err(sel_err), .drop_cnt(drop_cnt)
`endif
    );

    dmux_n_reg #(.W(16), .NCH(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .i(d3), .sel(sel3), .i_valid(i3_valid),
        .i_ready(i3_ready), .flush(flush3), .o(o3), .o_valid(o3_valid),
        .o_ready(o3_ready)
`ifdef DMUX_N_SELERR_EN
        , .sel_err(sel_err3), .drop_cnt(drop_cnt3)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus on the NCH=4 instance; expected words go into the scoreboard.
    task automatic cyc(input logic iv, input logic [1:0] s, input logic [15:0] d,
                       input logic fl, input logic [3:0] ordy);
        logic exp_rdy;
        @(negedge clk);
        i_valid = iv; sel = s; din = d; flush = fl; o_ready = ordy;
        #1;
        exp_rdy = !fl && (exp_q[s].size() == 0 || ordy[s]);
        check("i_ready", {63'd0, i_ready}, {63'd0, exp_rdy});
        #2;
        if (iv && exp_rdy) exp_q[s].push_back(d);
    endtask

    // Monitor: compares presented channels against the scoreboard, pops on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                for (int k = 0; k < 4; k++) begin
                    check($sformatf("o_valid[%0d]", k), {63'd0, o_valid[k]},
                          {63'd0, exp_q[k].size() != 0});
                    if (exp_q[k].size() != 0) begin
                        check($sformatf("o_data[%0d]", k), {48'd0, o[k*16 +: 16]},
                              {48'd0, exp_q[k][0]});
                        if (o_ready[k]) void'(exp_q[k].pop_front());
                    end
                end
                if (flush) begin
                    for (int k = 0; k < 4; k++) exp_q[k].delete();
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        i_valid = 0; sel = 0; din = 0; flush = 0; o_ready = 0;
        i3_valid = 0; sel3 = 0; d3 = 0; flush3 = 0; o3_ready = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset o_valid", {60'd0, o_valid}, 64'd0);
        check("reset o", o, 64'd0);

        // Routing
        cyc(1, 2'd2, 16'hA5A5, 0, 4'hF);
        cyc(0, 2'd0, 16'h0000, 0, 4'hF);
        check("route o_valid", {60'd0, o_valid}, 64'h4);
        check("route o[47:32]", {48'd0, o[47:32]}, 64'hA5A5);
        cyc(0, 2'd0, 16'h0000, 0, 4'hF);
        check("route drained", {60'd0, o_valid}, 64'h0);

        // Backpressure
        cyc(1, 2'd1, 16'h1111, 0, 4'b1101);
        cyc(1, 2'd1, 16'h2222, 0, 4'b1101);
        check("bp i_ready low", {63'd0, i_ready}, 64'd0);
        check("bp hold", {48'd0, o[31:16]}, 64'h1111);
        cyc(1, 2'd1, 16'h2222, 0, 4'b1111);
        check("bp i_ready high", {63'd0, i_ready}, 64'd1);
        cyc(0, 2'd0, 16'h0000, 0, 4'b0000);
        check("bp replaced", {48'd0, o[31:16]}, 64'h2222);
        check("bp valid kept", {63'd0, o_valid[1]}, 64'd1);
        cyc(0, 2'd0, 16'h0000, 0, 4'hF);

        // Parallel drain
        cyc(1, 2'd0, 16'h0001, 0, 4'b0000);
        cyc(1, 2'd3, 16'h0003, 0, 4'b0000);
        cyc(0, 2'd0, 16'h0000, 0, 4'b1111);
        check("pd both valid", {60'd0, o_valid}, 64'h9);
        cyc(0, 2'd0, 16'h0000, 0, 4'b0000);
        check("pd both clear", {60'd0, o_valid}, 64'h0);

        // Flush
        cyc(1, 2'd0, 16'h00F0, 0, 4'b0000);
        cyc(1, 2'd1, 16'h00F1, 0, 4'b0000);
        cyc(1, 2'd3, 16'h00F3, 0, 4'b0000);
        cyc(1, 2'd2, 16'hBEEF, 1, 4'b0000);
        check("flush pre v", {60'd0, o_valid}, 64'hB);
        check("flush i_ready", {63'd0, i_ready}, 64'd0);
        cyc(0, 2'd0, 16'h0000, 0, 4'b0000);
        check("flush cleared", {60'd0, o_valid}, 64'h0);

        // Asynchronous reset mid-cycle
        cyc(1, 2'd2, 16'hCAFE, 0, 4'b0000);
        cyc(0, 2'd0, 16'h0000, 0, 4'b0000);
        check("rst pre v2", {63'd0, o_valid[2]}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("async rst o_valid", {60'd0, o_valid}, 64'd0);
        check("async rst o", o, 64'd0);
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 16'($urandom),
                $urandom_range(0, 19) == 0, 4'($urandom));
        end
        cyc(0, 2'd0, 16'h0000, 0, 4'hF);
        cyc(0, 2'd0, 16'h0000, 0, 4'hF);

        // Out-of-range selects on NCH=3
        @(negedge clk);
        i3_valid = 1; sel3 = 2'd2; d3 = 16'h5A5A; o3_ready = 3'b000;
        for (int n = 0; n < 303; n++) begin
            @(negedge clk);
            sel3 = 2'd3; d3 = 16'($urandom);
            #1;
`ifdef DMUX_N_SELERR_EN
            if (n == 3) begin
                check("selerr flag", {63'd0, sel_err3}, 64'd1);
                check("drop_cnt 3", {56'd0, drop_cnt3}, 64'd3);
            end
`endif
            if (n < 4) begin
                check("oor i_ready", {63'd0, i3_ready}, 64'd1);
                check("oor o_valid", {61'd0, o3_valid}, 64'h4);
                check("oor ch2 kept", {48'd0, o3[47:32]}, 64'h5A5A);
            end
        end
        @(negedge clk);
        i3_valid = 0;
        #1;
        check("oor final o_valid", {61'd0, o3_valid}, 64'h4);
        check("oor final ch2", {48'd0, o3[47:32]}, 64'h5A5A);
`ifdef DMUX_N_SELERR_EN
        check("drop_cnt sat", {56'd0, drop_cnt3}, 64'd255);
        check("selerr main clear", {63'd0, sel_err}, 64'd0);
        check("drop main zero", {56'd0, drop_cnt}, 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
